com_uart8: RTL and testbench
============================

Name: com_uart8

Overview:
- Byte-wide UART peripheral on the CPU's 8-bit com bus (com_addr/com_wr/com_rd), directly downstream of risc8_cpu's datapath.
- Decodes a small register window and buffers transmit and receive bytes in FIFOs.
- Serialises and deserialises 8N1 frames on uart_tx/uart_rx.
- Supplies com_rd back to the CPU for reads in its window.

Parameters:
- DIVISOR, 434, clocks per bit (50 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, 2..256.
- BASE_ADDR, 8'h10, com address of DATA register; STATUS is BASE_ADDR+1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- com_addr  in  8  com bus address; 8'h00 = idle
- com_wr  in  8  com bus write data
- com_rd  out  8  com bus read data
- uart_tx  out  1  serial out, idle high
- uart_rx  in  1  serial in, asynchronous
- irq  out  1  high while RX FIFO non-empty

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on rising clk edge.
- Reset values:
  - uart_tx=1, irq=0.
  - Both FIFOs empty, TX and RX FSMs in IDLE.
  - Sticky flags (overrun, framing) cleared.
  - com_rd=8'h00 (not selected).
- Com bus protocol:
  - One access per cycle. The CPU drives a nonzero com_addr for exactly one cycle per access.
  - com_addr==BASE_ADDR: pushes com_wr into TX FIFO at the clock edge AND pops RX FIFO head at the clock edge (read/write share the register).
  - com_addr==BASE_ADDR+1: read STATUS; clears sticky flags at the clock edge.
  - Any other address: no effect; com_rd=8'h00.
- com_rd is combinational, zero latency:
  - DATA: RX head, or 8'h00 if RX empty.
  - STATUS bit map: [0] rx_nonempty, [1] rx_full, [2] tx_full, [3] tx_empty, [4] overrun, [5] framing_err, [7:6] 0.
- TX path:
  - Push when TX FIFO full: byte dropped, no other state change.
  - TX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if FIFO non-empty, pop head into shift reg and go to START on the next edge.
  - START: uart_tx=0 for DIVISOR clocks.
  - DATA: 8 bits LSB first, DIVISOR clocks each.
  - STOP: uart_tx=1 for DIVISOR clocks.
  - Back-to-back frames: after STOP, if FIFO non-empty, go directly to START (no extra idle cycles). Frame length = exactly 10*DIVISOR clocks.
  - tx_empty=1 only when FIFO empty AND FSM in IDLE.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - RX FSM states: IDLE -> START -> DATA -> STOP.
  - IDLE: synchronised falling edge (1->0) -> START, counter loaded with DIVISOR/2.
  - START: at count expiry, sample. If high, glitch -> IDLE with nothing pushed. If low -> DATA.
  - DATA: sample every DIVISOR clocks, 8 bits, LSB first.
  - STOP: sample after DIVISOR clocks.
    - High: push byte to RX FIFO.
    - Low: set framing_err, discard byte.
    - Either way -> IDLE.
- RX push when RX FIFO full: byte dropped, overrun set.
  - Exception: a DATA read (pop) in the same cycle as the push frees the slot; the push succeeds and overrun is not set.
- Same-cycle STATUS read and flag-set event: the set wins (flag remains 1).
- irq = rx_nonempty, registered from FIFO state (no combinational path from com bus).
- FIFO pointers: log2(FIFO_DEPTH)+1 bits; full/empty from MSB compare; wrap at FIFO_DEPTH.
- Reset mid-frame: uart_tx is high on the cycle after rst is sampled; partial RX frame discarded.

Test Plan:
- Reset: with DIVISOR=4, assert rst 2 cycles -> uart_tx=1, irq=0. STATUS read -> 8'h08.
- TX single byte: write 8'hA5 to 8'h10 -> uart_tx serial sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks, 40 clocks total. tx_empty=1 afterwards.
- TX back-to-back and full:
  - Write 17 bytes 8'h00..8'h10 in consecutive cycles while the TX FSM is busy on the first.
  - Required: 8'h00..8'h0F transmitted with no inter-frame gap; byte 8'h10 dropped; STATUS bit2=1 after the 16th push.
- RX loopback:
  - Drive 8'h3C frame on uart_rx -> irq=1 within 2 clocks of stop-bit sample; DATA read returns 8'h3C; irq=0 next cycle.
  - 2-cycle low glitch on uart_rx -> no push.
- RX errors:
  - 17 frames, no reads -> overrun=1 after the 17th. STATUS read returns bit4=1; next STATUS read returns bit4=0.
  - Frame with stop bit 0 -> framing_err=1 and no push.
- Simultaneous events:
  - RX FIFO full with DATA read in the exact stop-sample cycle -> overrun stays 0, count stays 16.
  - rst asserted mid-TX frame -> uart_tx=1 next cycle, TX FIFO empty.

Source files
------------

// File: rtl/com_uart8.sv
// com_uart8: byte-wide UART on the CPU com bus.
// A DATA register (TX push / RX pop) and a STATUS register sit at BASE_ADDR and
// BASE_ADDR+1. TX and RX are buffered in FIFOs and framed as 8N1 on uart_tx/uart_rx.
module com_uart8 #(
    parameter int unsigned DIVISOR    = 434,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  BASE_ADDR  = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] com_addr,
    input  logic [7:0] com_wr,
    output logic [7:0] com_rd,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       irq
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV     = 16'(DIVISOR);
    localparam logic [15:0] DIV_M1  = 16'(DIVISOR - 1);
    localparam logic [15:0] HALF    = 16'(DIVISOR / 2);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bus decode
    logic sel_data;
    logic sel_stat;
    assign sel_data = (com_addr == BASE_ADDR);
    assign sel_stat = (com_addr == (BASE_ADDR + 8'd1));

    // ------------------------------------------------------------------
    // TX FIFO and serialiser
    // ------------------------------------------------------------------
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp;
    logic [AW:0] tx_rp;
    logic        tx_fifo_empty;
    logic        tx_full;
    logic        tx_push;
    logic        tx_load;
    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_idle_empty;

    assign tx_fifo_empty = (tx_wp == tx_rp);
    assign tx_full       = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_push       = sel_data && !tx_full;
    // A new frame is loaded from idle, or straight out of the last stop-bit clock
    // so consecutive frames have no gap between them.
    assign tx_load       = !tx_fifo_empty &&
                           ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_cnt == 16'd0));
    assign tx_idle_empty = tx_fifo_empty && (tx_state == ST_IDLE);

    // TX FIFO storage write
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= com_wr;
    end

    // TX FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_load) tx_rp <= tx_rp + PTR_ONE;
        end
    end

    // TX frame sequencer: start, 8 data bits, stop, DIVISOR clocks each
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_load) begin
                        tx_state <= ST_START;
                        tx_cnt   <= DIV_M1;
                    end
                end
                ST_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= ST_DATA;
                        tx_cnt   <= DIV_M1;
                        tx_bit   <= 3'd0;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= DIV_M1;
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) tx_state <= ST_STOP;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt == 16'd0) begin
                        if (tx_load) begin
                            tx_state <= ST_START;
                            tx_cnt   <= DIV_M1;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // TX shift register: loaded with the FIFO head, shifted LSB-first per data bit
    always_ff @(posedge clk) begin
        if (tx_load) begin
            tx_sh <= tx_mem[tx_rp[AW-1:0]];
        end else if (tx_state == ST_DATA && tx_cnt == 16'd0) begin
            tx_sh <= {1'b0, tx_sh[7:1]};
        end
    end

    // Serial line level follows the frame phase; idle and stop are high
    always_comb begin
        case (tx_state)
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = tx_sh[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // RX synchroniser, deserialiser and FIFO
    // ------------------------------------------------------------------
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_expire;
    logic        rx_push_req;
    logic        ferr_set;
    logic        ovr_set;
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wp;
    logic [AW:0] rx_rp;
    logic [AW:0] rx_wp_nx;
    logic [AW:0] rx_rp_nx;
    logic        rx_empty;
    logic        rx_full;
    logic        rx_pop;
    logic        rx_push;
    logic        ovr;
    logic        ferr;

    assign rx_expire   = (rx_cnt == 16'd1);
    assign rx_push_req = (rx_state == ST_STOP) && rx_expire && rx_s2;
    assign ferr_set    = (rx_state == ST_STOP) && rx_expire && !rx_s2;
    assign rx_empty    = (rx_wp == rx_rp);
    assign rx_full     = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_pop      = sel_data && !rx_empty;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign ovr_set     = rx_push_req && rx_full && !rx_pop;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX frame sequencer: half-bit to the start-bit centre, then one bit per DIVISOR
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= ST_START;
                        rx_cnt   <= HALF;
                    end
                end
                ST_START: begin
                    if (rx_expire) begin
                        rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
                        rx_cnt   <= DIV;
                        rx_bit   <= 3'd0;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_expire) begin
                        rx_cnt <= DIV;
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_expire) begin
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // RX shift register: each data sample enters at the MSB, so LSB-first lands in place
    always_ff @(posedge clk) begin
        if (rx_state == ST_DATA && rx_expire) rx_sh <= {rx_s2, rx_sh[7:1]};
    end

    // RX FIFO storage write
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    // Next RX pointers, shared by the pointer registers and the irq register
    always_comb begin
        rx_wp_nx = rx_wp;
        rx_rp_nx = rx_rp;
        if (rx_push) rx_wp_nx = rx_wp + PTR_ONE;
        if (rx_pop)  rx_rp_nx = rx_rp + PTR_ONE;
    end

    // RX FIFO pointers and registered interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp <= '0;
            rx_rp <= '0;
            irq   <= 1'b0;
        end else begin
            rx_wp <= rx_wp_nx;
            rx_rp <= rx_rp_nx;
            irq   <= (rx_wp_nx != rx_rp_nx);
        end
    end

    // Sticky error flags: a STATUS read clears them unless a new event lands the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovr_set)       ovr <= 1'b1;
            else if (sel_stat) ovr <= 1'b0;
            if (ferr_set)      ferr <= 1'b1;
            else if (sel_stat) ferr <= 1'b0;
        end
    end

    // Combinational read mux for the register window
    always_comb begin
        com_rd = 8'h00;
        if (sel_data) begin
            com_rd = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
        end else if (sel_stat) begin
            com_rd = {2'b00, ferr, ovr, tx_idle_empty, tx_full, rx_full, !rx_empty};
        end
    end

endmodule

// File: tb/tb_com_uart8.sv
// tb_com_uart8: randomized and directed bench for com_uart8 with a queue-based
// behavioural model compared against the DUT outputs every cycle.
module tb_com_uart8;

    localparam int         D     = 4;
    localparam int         DEPTH = 16;
    localparam logic [7:0] BASE  = 8'h10;
    localparam logic [7:0] STAT  = 8'h11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] com_addr = 8'h00;
    logic [7:0] com_wr = 8'h00;
    logic [7:0] com_rd;
    logic       uart_tx;
    logic       uart_rx = 1'b1;
    logic       irq;

    always #5 clk = ~clk;

    com_uart8 #(.DIVISOR(D), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .com_addr(com_addr), .com_wr(com_wr), .com_rd(com_rd),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [7:0] m_txq[$];
    logic [7:0] m_rxq[$];
    bit         m_tbusy = 0;
    int         m_tt = 0;
    logic [7:0] m_tbyte = '0;
    bit         m_rbusy = 0;
    int         m_rtm = 0;
    logic [7:0] m_rbyte = '0;
    bit         m_s1 = 1, m_s2 = 1, m_prev = 1;
    bit         m_ovr = 0, m_fer = 0;
    bit         m_irq = 0;

    // Advance the model by one clock using the inputs the DUT sees at this edge
    always @(posedge clk) begin : model_step
        bit full_t, full_r, pop_r, push_r, ovr_set, fer_set;
        int k;
        if (rst) begin
            m_txq.delete(); m_rxq.delete();
            m_tbusy = 0; m_tt = 0; m_rbusy = 0; m_rtm = 0;
            m_s1 = 1; m_s2 = 1; m_prev = 1; m_ovr = 0; m_fer = 0;
        end else begin
            full_t = (m_txq.size() == DEPTH);
            if (m_txq.size() > 0 && (!m_tbusy || m_tt == 10*D-1)) begin
                m_tbyte = m_txq.pop_front(); m_tbusy = 1; m_tt = 0;
            end else if (m_tbusy) begin
                if (m_tt == 10*D-1) m_tbusy = 0; else m_tt++;
            end
            if (com_addr == BASE && !full_t) m_txq.push_back(com_wr);

            push_r = 0; fer_set = 0;
            if (!m_rbusy) begin
                if (m_prev && !m_s2) begin m_rbusy = 1; m_rtm = 0; end
            end else begin
                m_rtm++;
                if (m_rtm >= D/2 && (m_rtm - D/2) % D == 0) begin
                    k = (m_rtm - D/2) / D;
                    if (k == 0) begin
                        if (m_s2) m_rbusy = 0;
                    end else if (k <= 8) begin
                        m_rbyte[k-1] = m_s2;
                    end else begin
                        if (m_s2) push_r = 1; else fer_set = 1;
                        m_rbusy = 0;
                    end
                end
            end
            m_prev = m_s2; m_s2 = m_s1; m_s1 = uart_rx;

            full_r = (m_rxq.size() == DEPTH);
            pop_r  = (com_addr == BASE) && (m_rxq.size() > 0);
            if (pop_r) void'(m_rxq.pop_front());
            ovr_set = 0;
            if (push_r) begin
                if (full_r && !pop_r) ovr_set = 1; else m_rxq.push_back(m_rbyte);
            end
            if (com_addr == STAT) begin m_ovr = 0; m_fer = 0; end
            if (ovr_set) m_ovr = 1;
            if (fer_set) m_fer = 1;
        end
        m_irq = (m_rxq.size() > 0);
    end

    function automatic logic exp_tx();
        int b;
        if (!m_tbusy) return 1'b1;
        b = m_tt / D;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_tbyte[b-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_rd();
        logic [7:0] s;
        if (com_addr == BASE) return (m_rxq.size() > 0) ? m_rxq[0] : 8'h00;
        if (com_addr == STAT) begin
            s = {2'b00, m_fer, m_ovr, (m_txq.size() == 0 && !m_tbusy),
                 (m_txq.size() == DEPTH), (m_rxq.size() == DEPTH), (m_rxq.size() > 0)};
            return s;
        end
        return 8'h00;
    endfunction

    // Per-cycle comparison, half a clock away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("uart_tx", uart_tx, exp_tx());
            check("irq", irq, m_irq);
            check("com_rd", com_rd, exp_rd());
        end
    end

    // Independent decoder of the transmitted line
    logic [7:0] mon_q[$];
    bit         mon_busy = 0;
    int         mon_cnt = 0;
    logic [7:0] mon_b = '0;
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 0;
        end else if (!mon_busy) begin
            if (uart_tx === 1'b0) begin mon_busy = 1; mon_cnt = 0; end
        end else begin
            mon_cnt++;
            if (mon_cnt >= D/2 + D && mon_cnt <= D/2 + 8*D && (mon_cnt - D/2) % D == 0)
                mon_b[(mon_cnt - D/2)/D - 1] = uart_tx;
            if (mon_cnt == D/2 + 9*D && uart_tx === 1'b1) mon_q.push_back(mon_b);
            if (mon_cnt == 10*D - 1) mon_busy = 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end at posedge + 1)
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        com_addr = a; com_wr = d;
        cyc();
        com_addr = 8'h00; com_wr = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        com_addr = a; com_wr = 8'h00;
        #2 v = com_rd;
        cyc();
        com_addr = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0; repeat (D) cyc();
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (D) cyc(); end
        uart_rx = stop; repeat (D) cyc();
        uart_rx = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] v;
        logic [7:0] first_v;
        logic [9:0] seq_a5;
        bit         got;
        seq_a5 = 10'b1101001010;

        // Reset
        @(posedge clk); #1;
        chk_en = 1'b1;
        cyc();
        check("reset_uart_tx", uart_tx, 1'b1);
        check("reset_irq", irq, 1'b0);
        rst = 1'b0;
        rd(STAT, v);
        check("reset_status", v, 8'h08);

        // Single TX byte
        wr(BASE, 8'hA5);
        for (int i = 0; i < 10*D; i++) begin
            cyc();
            check("tx_a5_line", uart_tx, seq_a5[i/D]);
        end
        cyc();
        rd(STAT, v);
        check("tx_a5_done_status", v, 8'h08);

        // Back-to-back TX and TX full
        mon_q.delete();
        wr(BASE, 8'h55);
        idle(2);
        for (int i = 0; i < 17; i++) wr(BASE, 8'(i));
        rd(STAT, v);
        check("tx_full_bit", v[2], 1'b1);
        idle(17*10*D + 20);
        check("tx_frame_count", mon_q.size(), 17);
        if (mon_q.size() == 17) begin
            check("tx_frame_first", mon_q[0], 8'h55);
            for (int i = 0; i < 16; i++) check("tx_frame_seq", mon_q[i+1], 8'(i));
        end

        // RX loopback and glitch
        send_frame(8'h3C, 1'b1);
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (irq === 1'b1) got = 1; else cyc();
        end
        check("rx_irq_rise", got, 1'b1);
        rd(BASE, v);
        check("rx_data_3c", v, 8'h3C);
        check("rx_irq_fall", irq, 1'b0);
        uart_rx = 1'b0; idle(2); uart_rx = 1'b1;
        idle(20);
        rd(STAT, v);
        check("rx_glitch_nonempty", v[0], 1'b0);

        // RX overrun after 17 unread frames
        for (int i = 0; i < 17; i++) begin
            send_frame(8'h80 + 8'(i), 1'b1);
            idle(4);
        end
        rd(STAT, v);
        check("rx_overrun_set", v[4], 1'b1);
        check("rx_full_set", v[1], 1'b1);
        rd(STAT, v);
        check("rx_overrun_cleared", v[4], 1'b0);

        // Pop in the exact stop-sample cycle of a frame arriving at a full FIFO
        fork
            send_frame(8'hA0, 1'b1);
            begin
                got = 0;
                for (int i = 0; i < 100 && !got; i++) begin
                    cyc();
                    if (m_rbusy && m_rtm == D/2 + 9*D - 1) got = 1;
                end
                check("sim_align", got, 1'b1);
                if (got) begin
                    rd(BASE, v);
                    check("sim_pop_data", v, 8'h80);
                end
            end
        join
        idle(4);
        rd(STAT, v);
        check("sim_overrun_clear", v[4], 1'b0);
        check("sim_still_full", v[1], 1'b1);
        first_v = 8'h00;
        for (int i = 0; i < 16; i++) begin
            rd(BASE, v);
            if (i == 0) first_v = v;
        end
        check("drain_first", first_v, 8'h81);
        check("drain_last", v, 8'hA0);

        // Framing error
        send_frame(8'h5A, 1'b0);
        idle(6);
        rd(STAT, v);
        check("framing_set", v[5], 1'b1);
        check("framing_no_push", v[0], 1'b0);
        rd(STAT, v);
        check("framing_cleared", v[5], 1'b0);

        // Reset in the middle of a TX frame, then of an RX frame
        idle(20*10*D);
        wr(BASE, 8'hC3);
        wr(BASE, 8'h3C);
        idle(12);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("rst_mid_tx_line", uart_tx, 1'b1);
        rd(STAT, v);
        check("rst_mid_tx_status", v, 8'h08);
        fork
            send_frame(8'h96, 1'b1);
            begin idle(15); rst = 1'b1; cyc(); rst = 1'b0; end
        join
        idle(50);

        // Randomized traffic on both the bus and the serial input
        fork
            begin
                int r;
                for (int i = 0; i < 2000; i++) begin
                    r = $urandom_range(0, 99);
                    if (r < 40)      com_addr = 8'h00;
                    else if (r < 65) com_addr = BASE;
                    else if (r < 85) com_addr = STAT;
                    else             com_addr = 8'($urandom_range(0, 255));
                    com_wr = 8'($urandom);
                    cyc();
                end
                com_addr = 8'h00; com_wr = 8'h00;
            end
            begin
                int r;
                for (int f = 0; f < 40; f++) begin
                    r = $urandom_range(0, 9);
                    if (r == 0) begin
                        uart_rx = 1'b0;
                        repeat ($urandom_range(1, 2)) cyc();
                        uart_rx = 1'b1;
                    end else begin
                        send_frame(8'($urandom), (r != 1));
                    end
                    repeat ($urandom_range(0, 6)) cyc();
                end
                uart_rx = 1'b1;
            end
        join
        idle(DEPTH*10*D + 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
